// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce block: FSM state encodings and default timing.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    CHK1 = 2'b01,
    ONE  = 2'b10,
    CHK0 = 2'b11
  } state_t;

  localparam int TICK_DIV_DEF     = 1_000_000;
  localparam int STABLE_TICKS_DEF = 3;

endpackage

// File: rtl/debounce_multi_tick_gen.sv
// Free-running sample-tick divider: one-cycle pulse every TICK_DIV clocks.
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch debouncer: per-channel 2-flop synchroniser, tick-counted
// stability check and registered rise/fall strobes, sharing one tick_gen.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    logic          sync_p0;
    logic          sync_p1;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rise_q;
    logic          fall_q;

    // Stage p0/p1: synchroniser; then state, counter and edge strobes
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        state   <= ZERO;
        cnt     <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync_p0 <= sw_in[i];
        sync_p1 <= sync_p0;
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        rise_q  <= (state == CHK1) && (state_nxt == ONE);
        fall_q  <= (state == CHK0) && (state_nxt == ZERO);
      end
    end

    // A reversal of the input is tested before the tick so an abort always wins.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        ZERO: begin
          if (sync_p1) begin
            state_nxt = CHK1;
            cnt_nxt   = '0;
          end
        end
        CHK1: begin
          if (!sync_p1) begin
            state_nxt = ZERO;
          end else if (tick) begin
            if (cnt == CNT_LAST) state_nxt = ONE;
            else                 cnt_nxt   = cnt + 1'b1;
          end
        end
        ONE: begin
          if (!sync_p1) begin
            state_nxt = CHK0;
            cnt_nxt   = '0;
          end
        end
        CHK0: begin
          if (sync_p1) begin
            state_nxt = ONE;
          end else if (tick) begin
            if (cnt == CNT_LAST) state_nxt = ZERO;
            else                 cnt_nxt   = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ZERO;
          cnt_nxt   = '0;
        end
      endcase
    end

    // ONE and CHK0 share bit 1 of the encoding, so the level is a single flop bit.
    assign db_out[i] = state[1];
    assign rise[i]   = rise_q;
    assign fall[i]   = fall_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (N_CH=4, TICK_DIV=4, STABLE_TICKS=3).
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_in;
  logic [3:0] db_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       tick;

  debounce_multi #(.N_CH(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .db_out (db_out),
    .rise   (rise),
    .fall   (fall),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected event and its window.
  always @(negedge clk) begin
    if (rise != 4'b0 || fall != 4'b0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d got rise=%b fall=%b want none", cyc, rise, fall);
      end else begin
        mon_e = q.pop_front();
        total++;
        if (rise !== mon_e.rise || fall !== mon_e.fall || cyc < mon_e.lo || cyc > mon_e.hi) begin
          bad++;
          $display("FAIL strobe cyc=%0d got rise=%b fall=%b want rise=%b fall=%b in cyc %0d..%0d",
                   cyc, rise, fall, mon_e.rise, mon_e.fall, mon_e.lo, mon_e.hi);
        end
        total++;
        if (((rise & ~db_out) != 4'b0) || ((fall & db_out) != 4'b0) || ((rise & fall) != 4'b0)) begin
          bad++;
          $display("FAIL strobe_level cyc=%0d got db_out=%b rise=%b fall=%b", cyc, db_out, rise, fall);
        end
      end
    end else if (q.size() != 0 && cyc > q[0].hi) begin
      total++;
      bad++;
      $display("FAIL missing_strobe cyc=%0d want rise=%b fall=%b by cyc %0d", cyc, q[0].rise, q[0].fall, q[0].hi);
      void'(q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [3:0] r, input logic [3:0] f, input int d);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.lo   = d + 12;
    e.hi   = d + 15;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout got pending=%0d want 0", name, q.size());
      q.delete();
    end
    step(2);
  endtask

  task automatic wait_tick(output int t);
    int n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tick !== 1'b1) begin
      bad++;
      $display("FAIL tick_wait got tick=%b want 1", tick);
    end
    t = cyc;
  endtask

  initial begin
    int r;
    int t;
    int d;
    rst   = 1'b1;
    sw_in = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_db_out", 32'(db_out), 32'h0);
    check("rst_rise",   32'(rise),   32'h0);
    check("rst_fall",   32'(fall),   32'h0);
    check("rst_tick",   32'(tick),   32'h0);
    rst = 1'b0;
    r   = cyc;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (tick) break;
    end
    check("first_tick_cyc", 32'(cyc), 32'(r + 3));
    step(4);
    check("tick_period", 32'(tick), 32'h1);

    // Clean press on channel 0
    sw_in[0] = 1'b1;
    expect_ev(4'b0001, 4'b0000, cyc);
    drain("press");
    check("press_db", 32'(db_out), 32'h1);

    // Bounce on channel 1, then hold high
    for (int k = 0; k < 10; k++) begin
      sw_in[1] = (k % 2 == 0);
      step(3);
    end
    check("bounce_db", 32'(db_out), 32'h1);
    sw_in[1] = 1'b1;
    expect_ev(4'b0010, 4'b0000, cyc);
    drain("bounce");
    check("bounce_hold_db", 32'(db_out), 32'h3);

    // Release on channel 0, re-press, then release with a 1-cycle re-high glitch
    sw_in[0] = 1'b0;
    expect_ev(4'b0000, 4'b0001, cyc);
    drain("release");
    check("release_db", 32'(db_out), 32'h2);
    sw_in[0] = 1'b1;
    expect_ev(4'b0001, 4'b0000, cyc);
    drain("repress");
    sw_in[0] = 1'b0;
    step(6);
    sw_in[0] = 1'b1;
    step(1);
    sw_in[0] = 1'b0;
    expect_ev(4'b0000, 4'b0001, cyc);
    step(9);
    check("glitch_abort_db", 32'(db_out), 32'h3);
    drain("glitch_release");
    check("glitch_release_db", 32'(db_out), 32'h2);

    // Channel 2: input drops exactly as the final tick arrives
    wait_tick(t);
    sw_in[2] = 1'b1;
    step(10);
    sw_in[2] = 1'b0;
    step(2);
    check("abort_tick_aligned", 32'(tick), 32'h1);
    step(20);
    check("abort_vs_tick_db", 32'(db_out), 32'h2);

    // Channel 3: reset while CHK1 holds cnt=2
    wait_tick(t);
    sw_in[3] = 1'b1;
    step(10);
    rst = 1'b1;
    step(1);
    check("midrst_db",   32'(db_out), 32'h0);
    check("midrst_rise", 32'(rise),   32'h0);
    check("midrst_fall", 32'(fall),   32'h0);
    check("midrst_tick", 32'(tick),   32'h0);
    rst = 1'b0;
    d   = cyc;
    expect_ev(4'b1010, 4'b0000, d);
    step(3);
    check("tick_restart", 32'(tick), 32'h1);
    drain("midrst");
    check("midrst_after_db", 32'(db_out), 32'ha);

    // All channels together
    sw_in = 4'b0000;
    expect_ev(4'b0000, 4'b1010, cyc);
    drain("all_low");
    check("all_low_db", 32'(db_out), 32'h0);
    sw_in = 4'b1111;
    expect_ev(4'b1111, 4'b0000, cyc);
    drain("all_high");
    check("all_high_db", 32'(db_out), 32'hf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got cyc=%0d want finish", cyc);
    $fatal(1);
  end

endmodule
